interlock_cmd_conditioner: RTL and testbench

INTERLOCK_CMD_CONDITIONER -- requirements
Module: interlock_cmd_conditioner

---
 rtl/interlock_cmd_conditioner_if.sv | 22 ++
 rtl/interlock_cmd_conditioner.sv | 117 +++++++++++
 tb/tb_interlock_cmd_conditioner.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/interlock_cmd_conditioner_if.sv
// Command handshake between the conditioner (master) and the downstream
// interlock sequencer (slave).
interface interlock_cmd_conditioner_if;
   logic       cmd_valid;  // FIFO head holds a command
   logic [2:0] cmd_code;   // head command index, 0 when idle
   logic       cmd_ready;  // downstream accepts the head this cycle
   logic [5:0] cmd_pulse;  // one-hot of the command accepted this cycle

   modport master (
      output cmd_valid,
      output cmd_code,
      output cmd_pulse,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_code,
      input  cmd_pulse,
      output cmd_ready
   );
endinterface

// File: rtl/interlock_cmd_conditioner.sv
// Airlock command conditioner: synchronizes six asynchronous PIO level
// commands, turns rising edges into pending requests, serializes them in
// fixed priority into a 4-deep FIFO and hands them downstream with a
// valid/ready handshake. Pressurize and evacuate asserted together are
// rejected and latched as a sticky conflict.
module interlock_cmd_conditioner (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic [5:0]                         ctrl_in,
   interlock_cmd_conditioner_if.master        cmd,
   output logic [2:0]                         fifo_count,
   output logic                               conflict,
   output logic [3:0]                         drop_count
);

   localparam int unsigned DEPTH = 4;

   // Synchronizer and edge history
   logic [5:0] s1, s2, s3;
   // A bit may only produce an edge once a real low sample has been seen
   // since reset, so a level held high across reset never becomes a command.
   logic [5:0] armed;
   logic       primed;   // s1 holds a real post-reset sample

   logic [5:0] pending;
   logic [2:0] fifo_mem [DEPTH];
   logic [1:0] rd_ptr, wr_ptr;

   logic       collide;
   logic [5:0] edges, pend_live, drops, sel_onehot, pending_nxt;
   logic [2:0] sel_code, count_nxt, head_nxt;
   logic [1:0] rd_ptr_nxt;
   logic [4:0] drop_sum;
   logic       pop, push;

   // Edge detection, priority selection and FIFO next-state
   always_comb begin
      // NOTE: every signal gets a default before any condition so no latch is inferred.
      collide     = s2[4] & s2[5];
      edges       = s2 & ~s3 & armed;
      pend_live   = pending;
      if (collide) begin
         edges[5:4]     = 2'b00;
         pend_live[5:4] = 2'b00;
      end
      drops       = edges & pend_live;

      sel_code    = 3'd0;
      sel_onehot  = 6'b000000;
      for (int i = 5; i >= 0; i--) begin
         if (pend_live[i]) begin
            sel_code   = 3'(i);
            sel_onehot = 6'b000001 << i;
         end
      end

      pop         = cmd.cmd_valid & cmd.cmd_ready;
      push        = (pend_live != 6'b000000) && ((fifo_count != 3'd4) || pop);
      pending_nxt = (pend_live & ~(push ? sel_onehot : 6'b000000)) | (edges & ~pend_live);
      rd_ptr_nxt  = pop ? rd_ptr + 2'd1 : rd_ptr;
      count_nxt   = fifo_count + {2'b00, push} - {2'b00, pop};
      // A push into the slot that becomes the head bypasses the memory.
      head_nxt    = (push && (wr_ptr == rd_ptr_nxt)) ? sel_code : fifo_mem[rd_ptr_nxt];
      drop_sum    = {1'b0, drop_count} + 5'($countones(drops));
   end

   // Registered state and outputs; reset wins over any handshake or edge
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!reset_n) begin
         s1            <= '0;
         s2            <= '0;
         s3            <= '0;
         armed         <= '0;
         primed        <= 1'b0;
         pending       <= '0;
         rd_ptr        <= '0;
         wr_ptr        <= '0;
         fifo_count    <= '0;
         conflict      <= 1'b0;
         drop_count    <= '0;
         cmd.cmd_valid <= 1'b0;
         cmd.cmd_code  <= '0;
      end else begin
         s1            <= ctrl_in;
         s2            <= s1;
         s3            <= s2;
         primed        <= 1'b1;
         armed         <= armed | (primed ? ~s1 : 6'b000000);
         pending       <= pending_nxt;
         rd_ptr        <= rd_ptr_nxt;
         wr_ptr        <= push ? wr_ptr + 2'd1 : wr_ptr;
         fifo_count    <= count_nxt;
         conflict      <= conflict | collide;
         drop_count    <= (drop_sum > 5'd15) ? 4'd15 : drop_sum[3:0];
         cmd.cmd_valid <= (count_nxt != 3'd0);
         cmd.cmd_code  <= (count_nxt != 3'd0) ? head_nxt : 3'd0;
      end
   end

   // FIFO storage
   always_ff @(posedge clk) begin
      // NOTE: storage is not reset; pointers and count alone define which entries are valid.
      if (reset_n && push) begin
         fifo_mem[wr_ptr] <= sel_code;
      end
   end

   // Accept strobe, live only in a handshake cycle outside reset
   always_comb begin
      cmd.cmd_pulse = 6'b000000;
      if (reset_n && pop) begin
         cmd.cmd_pulse = 6'b000001 << cmd.cmd_code;
      end
   end

endmodule

// File: tb/tb_interlock_cmd_conditioner.sv
// Self-checking bench for interlock_cmd_conditioner: directed scenarios plus
// a randomized run compared against a queue-based reference model.
module tb_interlock_cmd_conditioner;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [5:0] ctrl_in;
   logic [2:0] fifo_count;
   logic       conflict;
   logic [3:0] drop_count;

   int checks   = 0;
   int failures = 0;

   interlock_cmd_conditioner_if bus ();

   interlock_cmd_conditioner dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .ctrl_in    (ctrl_in),
      .cmd        (bus),
      .fifo_count (fifo_count),
      .conflict   (conflict),
      .drop_count (drop_count)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Samples of ctrl_in taken since reset (newest last, at most three kept),
   // the command queue, the set of waiting requests, and the two status values.
   logic [5:0] hist [$];
   int         mq [$];
   logic [5:0] m_pend;
   int         m_drop;
   logic       m_conflict;

   // Advance the model by one clock edge using the inputs present before it.
   task automatic model_edge(input logic [5:0] c, input logic rdy, input logic rn);
      logic [5:0] s2v, s3v, edg, live, nxt;
      logic       cnf;
      bit         pop, push;
      int         sel;
      if (!rn) begin
         hist.delete();
         mq.delete();
         m_pend     = '0;
         m_drop     = 0;
         m_conflict = 1'b0;
         return;
      end
      s2v  = (hist.size() >= 2) ? hist[hist.size()-2] : 6'b000000;
      s3v  = (hist.size() >= 3) ? hist[hist.size()-3] : 6'b000000;
      cnf  = s2v[4] & s2v[5];
      // A rise counts only if the sample before it is a real post-reset low.
      edg  = (hist.size() >= 3) ? (s2v & ~s3v) : 6'b000000;
      live = m_pend;
      if (cnf) begin
         edg[5:4]  = 2'b00;
         live[5:4] = 2'b00;
      end
      m_drop = m_drop + $countones(edg & live);
      if (m_drop > 15) m_drop = 15;
      pop = (mq.size() > 0) && rdy;
      sel = -1;
      for (int i = 0; i < 6; i++) if (live[i] && sel < 0) sel = i;
      push = (sel >= 0) && ((mq.size() < 4) || pop);
      if (pop) void'(mq.pop_front());
      nxt = live;
      if (push) begin
         mq.push_back(sel);
         nxt[sel] = 1'b0;
      end
      m_pend     = nxt | (edg & ~live);
      m_conflict = m_conflict | cnf;
      hist.push_back(c);
      if (hist.size() > 3) void'(hist.pop_front());
   endtask

   // One clock: update the model, then land 1 ns after the rising edge.
   task automatic tick();
      model_edge(ctrl_in, bus.cmd_ready, reset_n);
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_bit(input int b);
      ctrl_in[b] = 1'b1;
      tick(); tick();
      ctrl_in[b] = 1'b0;
      tick(); tick();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset_n = 1'b0; ctrl_in = 6'b000000; bus.cmd_ready = 1'b1;
      tick(); tick();
      #1;
      checks++; if (fifo_count !== 3'd0)    begin failures++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
      checks++; if (bus.cmd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b want 0", bus.cmd_valid); end
      checks++; if (bus.cmd_code !== 3'd0)  begin failures++; $display("FAIL reset_code: got %0d want 0", bus.cmd_code); end
      checks++; if (bus.cmd_pulse !== 6'd0) begin failures++; $display("FAIL reset_pulse: got %b want 000000", bus.cmd_pulse); end
      checks++; if (conflict !== 1'b0)      begin failures++; $display("FAIL reset_conflict: got %0b want 0", conflict); end
      checks++; if (drop_count !== 4'd0)    begin failures++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
      reset_n = 1'b1; bus.cmd_ready = 1'b0;
      tick(); tick(); tick();
   endtask

   task automatic test_single();
      ctrl_in[2] = 1'b1;
      tick(); tick(); tick();   // edges k, k+1, k+2
      checks++; if (bus.cmd_valid !== 1'b0) begin failures++; $display("FAIL single_early: valid got %0b want 0 after k+2", bus.cmd_valid); end
      tick();                   // edge k+3
      checks++; if (bus.cmd_valid !== 1'b1) begin failures++; $display("FAIL single_valid: got %0b want 1 after k+3", bus.cmd_valid); end
      checks++; if (bus.cmd_code !== 3'd2)  begin failures++; $display("FAIL single_code: got %0d want 2", bus.cmd_code); end
      checks++; if (fifo_count !== 3'd1)    begin failures++; $display("FAIL single_count: got %0d want 1", fifo_count); end
      bus.cmd_ready = 1'b1;
      #1;
      checks++; if (bus.cmd_pulse !== 6'b000100) begin failures++; $display("FAIL single_pulse: got %b want 000100", bus.cmd_pulse); end
      tick();
      bus.cmd_ready = 1'b0;
      #1;
      checks++; if (fifo_count !== 3'd0)    begin failures++; $display("FAIL single_drain: count got %0d want 0", fifo_count); end
      checks++; if (bus.cmd_pulse !== 6'd0) begin failures++; $display("FAIL single_pulse_idle: got %b want 000000", bus.cmd_pulse); end
      ctrl_in = 6'b000000;
      tick(); tick(); tick(); tick();
   endtask

   task automatic test_simultaneous();
      int exp_seq [3] = '{0, 1, 3};
      logic [5:0] exp_p;
      ctrl_in = 6'b001011;
      tick(); tick(); tick();
      for (int n = 1; n <= 3; n++) begin
         tick();
         checks++; if (fifo_count !== 3'(n)) begin failures++; $display("FAIL simul_count%0d: got %0d want %0d", n, fifo_count, n); end
      end
      checks++; if (bus.cmd_code !== 3'd0) begin failures++; $display("FAIL simul_head: got %0d want 0", bus.cmd_code); end
      bus.cmd_ready = 1'b1;
      for (int n = 0; n < 3; n++) begin
         #1;
         exp_p = 6'b000001 << exp_seq[n];
         checks++; if (bus.cmd_pulse !== exp_p) begin failures++; $display("FAIL simul_order%0d: pulse got %b want %b", n, bus.cmd_pulse, exp_p); end
         tick();
      end
      bus.cmd_ready = 1'b0;
      checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL simul_empty: count got %0d want 0", fifo_count); end
      ctrl_in = 6'b000000;
      tick(); tick(); tick(); tick();
   endtask

   task automatic test_overflow();
      int exp_seq [10] = '{0, 1, 2, 3, 0, 1, 2, 3, 4, 5};
      logic [5:0] exp_p;
      int  n = 0;
      bit  first = 1'b1;
      for (int r = 0; r < 2; r++)
         for (int b = 0; b < 6; b++) pulse_bit(b);
      tick(); tick(); tick(); tick();
      checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL ovf_full: count got %0d want 4", fifo_count); end
      checks++; if (drop_count !== 4'd2) begin failures++; $display("FAIL ovf_drop: got %0d want 2", drop_count); end
      checks++; if (bus.cmd_code !== 3'd0) begin failures++; $display("FAIL ovf_head: got %0d want 0", bus.cmd_code); end
      bus.cmd_ready = 1'b1;
      for (int cyc = 0; cyc < 40 && n < 10; cyc++) begin
         #1;
         if (bus.cmd_pulse !== 6'd0) begin
            exp_p = 6'b000001 << exp_seq[n];
            checks++; if (bus.cmd_pulse !== exp_p) begin failures++; $display("FAIL ovf_order%0d: pulse got %b want %b", n, bus.cmd_pulse, exp_p); end
            n++;
         end
         tick();
         if (first) begin
            first = 1'b0;
            checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL full_handshake: count got %0d want 4", fifo_count); end
         end
      end
      checks++; if (n != 10) begin failures++; $display("FAIL ovf_drain_timeout: got %0d commands want 10", n); end
      bus.cmd_ready = 1'b0;
      checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL ovf_empty: count got %0d want 0", fifo_count); end
      checks++; if (drop_count !== 4'd2) begin failures++; $display("FAIL ovf_drop_hold: got %0d want 2", drop_count); end
   endtask

   task automatic test_conflict();
      ctrl_in = 6'b110000;
      for (int i = 0; i < 6; i++) tick();
      checks++; if (conflict !== 1'b1)      begin failures++; $display("FAIL cnf_set: got %0b want 1", conflict); end
      checks++; if (fifo_count !== 3'd0)    begin failures++; $display("FAIL cnf_no_cmd: count got %0d want 0", fifo_count); end
      checks++; if (drop_count !== 4'd2)    begin failures++; $display("FAIL cnf_drop: got %0d want 2", drop_count); end
      ctrl_in = 6'b000000;
      for (int i = 0; i < 4; i++) tick();
      checks++; if (conflict !== 1'b1)      begin failures++; $display("FAIL cnf_sticky: got %0b want 1", conflict); end
      checks++; if (bus.cmd_valid !== 1'b0) begin failures++; $display("FAIL cnf_valid: got %0b want 0", bus.cmd_valid); end
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      checks++; if (conflict !== 1'b0)      begin failures++; $display("FAIL cnf_cleared: got %0b want 0", conflict); end
      tick(); tick(); tick();
   endtask

   task automatic test_reset_mid();
      for (int b = 0; b < 4; b++) pulse_bit(b);
      for (int i = 0; i < 6; i++) pulse_bit(4);   // first waits, five are lost
      ctrl_in = 6'b110000;
      tick(); tick(); tick(); tick();
      ctrl_in = 6'b000000;
      tick(); tick(); tick();
      bus.cmd_ready = 1'b1;
      tick();
      bus.cmd_ready = 1'b0;
      tick();
      checks++; if (fifo_count !== 3'd3) begin failures++; $display("FAIL mid_count: got %0d want 3", fifo_count); end
      checks++; if (conflict !== 1'b1)   begin failures++; $display("FAIL mid_conflict: got %0b want 1", conflict); end
      checks++; if (drop_count !== 4'd5) begin failures++; $display("FAIL mid_drop: got %0d want 5", drop_count); end
      ctrl_in[1] = 1'b1;
      tick(); tick(); tick();
      bus.cmd_ready = 1'b1;
      reset_n = 1'b0;
      #1;
      checks++; if (bus.cmd_pulse !== 6'd0) begin failures++; $display("FAIL mid_pulse_in_reset: got %b want 000000", bus.cmd_pulse); end
      tick();
      reset_n = 1'b1; bus.cmd_ready = 1'b0;
      checks++; if (fifo_count !== 3'd0)    begin failures++; $display("FAIL mid_rst_count: got %0d want 0", fifo_count); end
      checks++; if (bus.cmd_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid: got %0b want 0", bus.cmd_valid); end
      checks++; if (bus.cmd_code !== 3'd0)  begin failures++; $display("FAIL mid_rst_code: got %0d want 0", bus.cmd_code); end
      checks++; if (conflict !== 1'b0)      begin failures++; $display("FAIL mid_rst_conflict: got %0b want 0", conflict); end
      checks++; if (drop_count !== 4'd0)    begin failures++; $display("FAIL mid_rst_drop: got %0d want 0", drop_count); end
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++; if (bus.cmd_valid !== 1'b0) begin failures++; $display("FAIL held_high_cycle%0d: valid got %0b want 0", i, bus.cmd_valid); end
      end
      ctrl_in[1] = 1'b0;
      tick(); tick(); tick();
      ctrl_in[1] = 1'b1;
      tick(); tick(); tick(); tick();
      checks++; if (bus.cmd_valid !== 1'b1 || bus.cmd_code !== 3'd1) begin
         failures++; $display("FAIL rearm: valid/code got %0b/%0d want 1/1", bus.cmd_valid, bus.cmd_code);
      end
      ctrl_in = 6'b000000;
      bus.cmd_ready = 1'b1;
      tick(); tick();
      bus.cmd_ready = 1'b0;
   endtask

   task automatic test_random();
      logic [5:0] exp_p;
      int b;
      reset_n = 1'b0; ctrl_in = 6'b000000; bus.cmd_ready = 1'b0;
      tick();
      reset_n = 1'b1;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         if ($urandom_range(0, 4) == 0) begin
            b = $urandom_range(0, 5);
            ctrl_in[b] = ~ctrl_in[b];
         end
         bus.cmd_ready = ($urandom_range(0, 3) == 0);
         reset_n       = ($urandom_range(0, 399) != 0);
         #1;
         exp_p = (reset_n && bus.cmd_ready && mq.size() > 0) ? (6'b000001 << mq[0]) : 6'b000000;
         checks++; if (bus.cmd_pulse !== exp_p) begin failures++; $display("FAIL rnd_pulse@%0d: got %b want %b", cyc, bus.cmd_pulse, exp_p); end
         tick();
         checks++; if (fifo_count !== 3'(mq.size())) begin failures++; $display("FAIL rnd_count@%0d: got %0d want %0d", cyc, fifo_count, mq.size()); end
         checks++; if (bus.cmd_valid !== (mq.size() > 0)) begin failures++; $display("FAIL rnd_valid@%0d: got %0b want %0b", cyc, bus.cmd_valid, mq.size() > 0); end
         checks++; if (bus.cmd_code !== ((mq.size() > 0) ? 3'(mq[0]) : 3'd0)) begin failures++; $display("FAIL rnd_code@%0d: got %0d", cyc, bus.cmd_code); end
         checks++; if (conflict !== m_conflict) begin failures++; $display("FAIL rnd_conflict@%0d: got %0b want %0b", cyc, conflict, m_conflict); end
         checks++; if (drop_count !== 4'(m_drop)) begin failures++; $display("FAIL rnd_drop@%0d: got %0d want %0d", cyc, drop_count, m_drop); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_simultaneous();
      test_overflow();
      test_conflict();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
